// File: rtl/param_priority_encoder_rr.sv
// Purpose: registered N-to-log2(N) priority encoder, fixed (MSB wins) or round-robin mode.
// Latency: one cycle from din to dout; one result per cycle while out_ready is high.
// Backpressure: while out_valid && !out_ready the result, multi flag and pointer hold and din is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   din        N request lines, any number may be set
//   mode_sel   requested mode (0 fixed, 1 round-robin), loaded only while idle
//   out_ready  consumer accepts dout this cycle
//   dout       encoded winning index
//   out_valid  dout/multi hold an unaccepted result
//   multi      more than one request was set when the result was captured
//   mode       current mode register
module param_priority_encoder_rr #(
    parameter int N          = 8,
    parameter int W          = $clog2(N),
    parameter bit RR_DEFAULT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         mode_sel,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output logic         out_valid,
    output logic         multi,
    output logic         mode
);

    logic [W-1:0] ptr;
    logic         free;
    logic         any;
    logic         many;
    logic [W-1:0] fix_idx;
    logic [W-1:0] lo_idx;
    logic [W-1:0] hi_idx;
    logic         hi_hit;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win;
    logic [W-1:0] ptr_nxt;

    assign free = !out_valid || out_ready;
    assign any  = |din;
    // Clearing the lowest set bit leaves something behind only if two or more were set.
    assign many = (din & (din - N'(1))) != '0;

    // Fixed priority: ascending scan so the highest set bit is the last assignment.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (din[i]) begin
                fix_idx = W'(i);
            end
        end
    end

    // Round-robin: the lowest set bit at or above ptr wins; if none exists the
    // scan has wrapped, so the lowest set bit overall wins. Descending loop so
    // the last assignment is the lowest index.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (din[i]) begin
                lo_idx = W'(i);
                if (i >= int'(ptr)) begin
                    hi_idx = W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
    end

    assign rr_idx = hi_hit ? hi_idx : lo_idx;
    assign win    = mode ? rr_idx : fix_idx;

    // Wrap explicitly at N-1 so non-power-of-two N never points past the last line.
    assign ptr_nxt = (win == W'(N - 1)) ? '0 : win + W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
            multi     <= 1'b0;
            ptr       <= '0;
            mode      <= RR_DEFAULT;
        end else begin
            // Mode changes only when nothing is pending and nothing is requested.
            if (!out_valid && !any) begin
                mode <= mode_sel;
            end
            if (free) begin
                if (any) begin
                    dout      <= win;
                    multi     <= many;
                    out_valid <= 1'b1;
                    ptr       <= ptr_nxt;
                end else begin
                    // dout/multi keep their last values; they are meaningless without valid.
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_priority_encoder_rr.sv
module tb_param_priority_encoder_rr;

    logic       clk;
    // N = 8 instance
    logic       rst8, ms8, rdy8;
    logic [7:0] din8;
    logic [2:0] dout8;
    logic       v8, mul8, mode8;
    // N = 5 instance, round-robin out of reset
    logic       rst5, ms5, rdy5;
    logic [4:0] din5;
    logic [2:0] dout5;
    logic       v5, mul5, mode5;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    param_priority_encoder_rr #(.N(8), .RR_DEFAULT(1'b0)) dut8 (
        .clk(clk), .rst_n(rst8), .din(din8), .mode_sel(ms8), .out_ready(rdy8),
        .dout(dout8), .out_valid(v8), .multi(mul8), .mode(mode8)
    );

    param_priority_encoder_rr #(.N(5), .RR_DEFAULT(1'b1)) dut5 (
        .clk(clk), .rst_n(rst5), .din(din5), .mode_sel(ms5), .out_ready(rdy5),
        .dout(dout5), .out_valid(v5), .multi(mul5), .mode(mode5)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner from the plain rules: fixed = highest set index; round-robin =
    // first set bit walking up from p modulo n.
    function automatic int winner(input logic [7:0] d, input int n, input int md, input int p);
        int w;
        w = 0;
        if (md == 0) begin
            for (int i = 0; i < n; i++) if (d[i]) w = i;
        end else begin
            for (int k = n - 1; k >= 0; k--) if (d[(p + k) % n]) w = (p + k) % n;
        end
        return w;
    endfunction

    // Reference state per instance
    int m8_v, m8_d, m8_m, m8_p, m8_mode;
    int m5_v, m5_d, m5_m, m5_p, m5_mode;

    always @(posedge clk) begin
        bit idle;
        int w;
        if (!rst8) begin
            m8_v = 0; m8_d = 0; m8_m = 0; m8_p = 0; m8_mode = 0;
        end else begin
            idle = (m8_v == 0) && (din8 == 0);
            if (m8_v == 0 || rdy8) begin
                if (din8 != 0) begin
                    w = winner(din8, 8, m8_mode, m8_p);
                    m8_d = w; m8_v = 1;
                    m8_m = ($countones(din8) > 1) ? 1 : 0;
                    m8_p = (w + 1) % 8;
                end else begin
                    m8_v = 0;
                end
            end
            if (idle) m8_mode = ms8;
        end
    end

    always @(posedge clk) begin
        bit idle;
        int w;
        if (!rst5) begin
            m5_v = 0; m5_d = 0; m5_m = 0; m5_p = 0; m5_mode = 1;
        end else begin
            idle = (m5_v == 0) && (din5 == 0);
            if (m5_v == 0 || rdy5) begin
                if (din5 != 0) begin
                    w = winner({3'b000, din5}, 5, m5_mode, m5_p);
                    m5_d = w; m5_v = 1;
                    m5_m = ($countones(din5) > 1) ? 1 : 0;
                    m5_p = (w + 1) % 5;
                end else begin
                    m5_v = 0;
                end
            end
            if (idle) m5_mode = ms5;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model8_valid", v8, m8_v);
            chk("model8_dout", dout8, m8_d);
            chk("model8_multi", mul8, m8_m);
            chk("model8_mode", mode8, m8_mode);
            chk("model5_valid", v5, m5_v);
            chk("model5_dout", dout5, m5_d);
            chk("model5_multi", mul5, m5_m);
            chk("model5_mode", mode5, m5_mode);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        rst8 = 0; din8 = 8'hFF; ms8 = 0; rdy8 = 1;
        rst5 = 0; din5 = 5'b0; ms5 = 0; rdy5 = 1;

        // Reset with all requests asserted
        tick(); tick();
        chk("rst_valid", v8, 0);
        chk("rst_dout", dout8, 0);
        chk("rst_multi", mul8, 0);
        chk("rst_mode", mode8, 0);
        chk_en = 1;
        rst8 = 1;
        tick();
        chk("post_rst_dout", dout8, 7);
        chk("post_rst_valid", v8, 1);
        chk("post_rst_multi", mul8, 1);

        // Fixed-mode one-hot sweep
        for (int k = 7; k >= 0; k--) begin
            b = 8'h01;
            din8 = b << k;
            tick();
            chk("sweep_dout", dout8, k);
            chk("sweep_multi", mul8, 0);
        end

        // Winner 7 brings ptr back to 0, then go idle and switch to round-robin
        din8 = 8'h80;
        tick();
        chk("ptr_reset_dout", dout8, 7);
        din8 = 8'h00; ms8 = 1;
        tick();
        chk("idle_mode_held", mode8, 0);
        tick();
        chk("idle_mode_loaded", mode8, 1);
        chk("idle_valid", v8, 0);

        // Round-robin fairness on all-ones
        din8 = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rr_fair_dout", dout8, k % 8);
            chk("rr_fair_multi", mul8, 1);
        end

        // Skip and wrap: winner 5 leaves ptr at 6
        din8 = 8'b0010_0000;
        tick();
        chk("skip_setup_dout", dout8, 5);
        din8 = 8'b0000_1001;
        tick();
        chk("skip_wrap_dout", dout8, 0);
        tick();
        chk("skip_next_dout", dout8, 3);

        // Stall and hold
        din8 = 8'b0010_0000;
        tick();
        chk("stall_cap_dout", dout8, 5);
        rdy8 = 0; din8 = 8'b0000_0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_dout", dout8, 5);
            chk("stall_valid", v8, 1);
        end
        rdy8 = 1;
        tick();
        chk("stall_release_dout", dout8, 1);

        // Randomised traffic on the 8-line instance
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 3))
                0: din8 = 8'h00;
                1: begin b = 8'h01; din8 = b << $urandom_range(0, 7); end
                default: din8 = 8'($urandom);
            endcase
            rdy8 = ($urandom_range(0, 3) != 0);
            ms8  = 1'($urandom);
            rst8 = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst8 = 1; din8 = 8'h00; rdy8 = 1;

        // N = 5: reset loads round-robin mode
        rst5 = 0; din5 = 5'b10001; ms5 = 1;
        tick();
        chk("n5_rst_mode", mode5, 1);
        chk("n5_rst_valid", v5, 0);
        chk("n5_rst_dout", dout5, 0);
        rst5 = 1;
        tick();
        chk("n5_dout_a", dout5, 0);
        tick();
        chk("n5_dout_b", dout5, 4);
        tick();
        chk("n5_dout_c", dout5, 0);
        rst5 = 0;
        tick();
        chk("n5_midrst_valid", v5, 0);
        rst5 = 1;
        tick();
        chk("n5_after_rst_dout", dout5, 0);
        chk("n5_after_rst_valid", v5, 1);

        // Randomised traffic on the 5-line instance
        for (int c = 0; c < 1500; c++) begin
            din5 = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom);
            rdy5 = ($urandom_range(0, 3) != 0);
            ms5  = 1'($urandom);
            rst5 = ($urandom_range(0, 99) != 0);
            tick();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_priority_encoder_rr.md
Name: param_priority_encoder_rr

Overview:
- Registered, parametrised N-to-log2(N) encoder. Successor to the fixed 8-to-3 combinational encoder.
- Adds a runtime-selectable mode: fixed priority (MSB wins) or round-robin fairness with a rotating pointer.
- Adds a one-deep output register with a valid/ready handshake and a multi-hot flag.
- Sits between request sources (interrupt or arbiter lines) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request lines; legal range 2..256; need not be a power of two.
- W, $clog2(N), width of encoded index; derived, never overridden.
- RR_DEFAULT, 0, mode loaded into the mode register at reset (0 = fixed, 1 = round-robin).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- din  input  N  request vector; any number of bits may be set.
- mode_sel  input  1  requested mode (0 fixed, 1 round-robin); takes effect only when the block is idle.
- out_ready  input  1  downstream accepts dout this cycle.
- dout  output  W  encoded index of the winning request.
- out_valid  output  1  dout/multi hold a result not yet accepted.
- multi  output  1  more than one din bit was set when the result was captured.
- mode  output  1  current mode register.

Behaviour:
- Reset (rst_n = 0 at a rising edge): dout = 0, out_valid = 0, multi = 0, ptr = 0, mode = RR_DEFAULT.
  - Reset overrides everything, including a pending unaccepted result, which is discarded.
- Slot free condition: free = !out_valid || out_ready.
- Capture, on a rising edge with free = 1:
  - din != 0: dout = winning index, out_valid = 1, multi = (popcount(din) > 1).
  - din == 0: out_valid = 0; dout and multi keep their last values (don't-care to the consumer).
- Stall (out_valid = 1 && out_ready = 0): dout, multi, out_valid and ptr all hold; din is ignored (not queued).
- Latency: 1 cycle from din to dout. Back-to-back throughput: 1 result per cycle while out_ready = 1.
- Fixed mode (mode = 0): winner is the highest set bit index (MSB priority). ptr is not used but is still updated as below.
- Round-robin mode (mode = 1):
  - Scan din starting at index ptr, ascending, wrapping from N-1 to 0; the first set bit wins.
- Pointer update, on every capture with din != 0 (either mode):
  - ptr = winner + 1, wrapping to 0 when winner = N-1. Non-power-of-two N wraps at N-1, never at 2^W - 1.
- Mode register:
  - Loads mode_sel only on an edge where out_valid = 0 and din == 0 (idle). Otherwise mode holds.
  - On a mode change, ptr is not reset.
- Simultaneous capture and accept (out_valid = 1, out_ready = 1, din != 0): the old result is consumed and the new result is loaded in the same edge; out_valid stays 1.
- Single-bit din: multi = 0, and both modes give the same index.
- All-ones din in round-robin mode: successive captures cycle ptr, ptr+1, ... mod N.

Test Plan:
- Reset with N = 8, RR_DEFAULT = 0: hold rst_n = 0 for 2 edges while din = 8'hFF -> out_valid = 0, dout = 0, multi = 0, mode = 0. Release; next edge -> dout = 7, out_valid = 1, multi = 1.
- Fixed one-hot sweep: din = 8'b10000000 down to 8'b00000001, one per cycle, out_ready = 1 -> dout = 7, 6, ..., 0, each 1 cycle later; multi = 0 throughout.
- Round-robin fairness:
  - Setup: mode_sel = 1 applied while idle, din = 8'hFF held, out_ready = 1.
  - Required: dout = 0, 1, 2, ..., 7, 0, 1 on consecutive cycles; multi = 1.
- Round-robin skip and wrap:
  - Setup: ptr = 6 (after a winner of 5), din = 8'b00001001.
  - Required: dout = 0, ptr becomes 1. Next din = 8'b00001001 -> dout = 3.
- Stall/hold: capture din = 8'b00100000 (dout = 5), then out_ready = 0 for 3 cycles while din = 8'b00000010 -> dout stays 5 and out_valid stays 1. Raise out_ready -> next edge dout = 1.
- N = 5 (W = 3), round-robin, din = 5'b10001 from ptr = 0 -> dout = 0, 4, 0 (wraps at 4, never reports 5-7). Mid-stream rst_n = 0 -> out_valid = 0, ptr = 0, and the next capture is dout = 0.
